// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES state geometry and byte addressing shared by the round datapath stages.
package aes_pkg;

   localparam int NB_BYTE  = 8;
   localparam int N_BYTES  = 16;
   localparam int N_ROWS   = 4;
   localparam int N_COLS   = 4;
   localparam int NB_STATE = N_BYTES * NB_BYTE;

   // Occupancy of a two-entry main/skid pipeline stage, encoded as {main_valid, skid_valid}.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_FULL1 = 2'b10,
      OCC_FULL2 = 2'b11
   } occ_e;

   // LSB position of state byte (row, col); byte 0 (row 0, col 0) sits on the MSBs.
   function automatic int byte_lsb(input int row, input int col);
      return (N_BYTES - 1 - (N_ROWS * col + row)) * NB_BYTE;
   endfunction

endpackage

// File: rtl/shiftrows_comb.sv
// rtl/shiftrows_comb.sv - combinational ShiftRows; adds an InvShiftRows select when SHIFTROWS_PIPE_INV_EN is defined.
module shiftrows_comb
   import aes_pkg::*;
(
   input  logic [NB_STATE-1:0] state_i,
`ifdef SHIFTROWS_PIPE_INV_EN
   input  logic                inverse_i,
`endif
   output logic [NB_STATE-1:0] state_o
);

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      for (genvar c = 0; c < N_COLS; c++) begin : g_col
         localparam int DST     = byte_lsb(r, c);
         localparam int SRC_FWD = byte_lsb(r, (c + r) % N_COLS);
`ifdef SHIFTROWS_PIPE_INV_EN
         localparam int SRC_INV = byte_lsb(r, (c + N_COLS - r) % N_COLS);
         assign state_o[DST +: NB_BYTE] = inverse_i ? state_i[SRC_INV +: NB_BYTE]
                                                    : state_i[SRC_FWD +: NB_BYTE];
`else
         assign state_o[DST +: NB_BYTE] = state_i[SRC_FWD +: NB_BYTE];
`endif
      end
   end

endmodule

// File: rtl/shiftrows_pipe_stage.sv
// rtl/shiftrows_pipe_stage.sv - registered ShiftRows stage with valid/ready and a 2-entry skid buffer.
// Optional: SHIFTROWS_PIPE_INV_EN adds i_inverse to select InvShiftRows per word.
module shiftrows_pipe_stage #(
   parameter int NB_BYTE = 8,
   parameter int N_BYTES = 16,
   parameter int NB_TAG  = 4
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [N_BYTES*NB_BYTE-1:0] i_state,
   input  logic [NB_TAG-1:0]          i_tag,
   input  logic                       i_valid,
`ifdef SHIFTROWS_PIPE_INV_EN
   input  logic                       i_inverse,
`endif
   output logic                       o_ready,
   output logic [N_BYTES*NB_BYTE-1:0] o_state,
   output logic [NB_TAG-1:0]          o_tag,
   output logic                       o_valid,
   input  logic                       i_ready
);

   localparam int NB_ST = N_BYTES * NB_BYTE;

   if (NB_BYTE != 8 || N_BYTES != 16) begin : g_bad_conf
      $error("BAD_CONF: shiftrows_pipe_stage supports only NB_BYTE=8 and N_BYTES=16");
   end

   logic [NB_ST-1:0]  shifted;
   logic              in_xfer;
   logic              out_xfer;
   logic              skid_load;
   aes_pkg::occ_e     occ;

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              ready_q, ready_d;
   logic [NB_ST-1:0]  main_state_q, main_state_d;
   logic [NB_TAG-1:0] main_tag_q, main_tag_d;
   logic [NB_ST-1:0]  skid_state_q;
   logic [NB_TAG-1:0] skid_tag_q;

   shiftrows_comb u_shiftrows_comb (
      .state_i   (i_state),
`ifdef SHIFTROWS_PIPE_INV_EN
      .inverse_i (i_inverse),
`endif
      .state_o   (shifted)
   );

   assign in_xfer  = i_valid & ready_q;
   assign out_xfer = main_valid_q & i_ready;
   assign occ      = aes_pkg::occ_e'({main_valid_q, skid_valid_q});

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_state_d = main_state_q;
      main_tag_d   = main_tag_q;
      skid_load    = 1'b0;
      case (occ)
         aes_pkg::OCC_EMPTY: begin
            if (in_xfer) begin
               main_valid_d = 1'b1;
               main_state_d = shifted;
               main_tag_d   = i_tag;
            end
         end
         aes_pkg::OCC_FULL1: begin
            if (in_xfer && out_xfer) begin
               main_state_d = shifted;
               main_tag_d   = i_tag;
            end else if (out_xfer) begin
               main_valid_d = 1'b0;
            end else if (in_xfer) begin
               skid_valid_d = 1'b1;
               skid_load    = 1'b1;
            end
         end
         aes_pkg::OCC_FULL2: begin
            // Upstream is blocked here, so only the drain of main can happen.
            if (out_xfer) begin
               skid_valid_d = 1'b0;
               main_state_d = skid_state_q;
               main_tag_d   = skid_tag_q;
            end
         end
         default: begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
         end
      endcase
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         main_state_q <= '0;
         main_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         main_state_q <= main_state_d;
         main_tag_q   <= main_tag_d;
      end
   end

   always_ff @(posedge i_clock) begin
      if (skid_load) begin
         skid_state_q <= shifted;
         skid_tag_q   <= i_tag;
      end
   end

   assign o_ready = ready_q;
   assign o_valid = main_valid_q;
   assign o_state = main_state_q;
   assign o_tag   = main_tag_q;

endmodule

// File: tb/tb_shiftrows_pipe_stage.sv
// tb/tb_shiftrows_pipe_stage.sv - scoreboard bench for shiftrows_pipe_stage with a byte-level ShiftRows model.
module tb_shiftrows_pipe_stage;

   localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] i_state;
   logic [3:0]   i_tag;
   logic         i_valid;
   logic         i_inverse;
   logic         o_ready;
   logic [127:0] o_state;
   logic [3:0]   o_tag;
   logic         o_valid;
   logic         i_ready;
   logic         rnd_rdy = 1'b0;

   logic [131:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shiftrows_pipe_stage #(.NB_BYTE(8), .N_BYTES(16), .NB_TAG(4)) dut (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_state   (i_state),
      .i_tag     (i_tag),
      .i_valid   (i_valid),
`ifdef SHIFTROWS_PIPE_INV_EN
      .i_inverse (i_inverse),
`endif
      .o_ready   (o_ready),
      .o_state   (o_state),
      .o_tag     (o_tag),
      .o_valid   (o_valid),
      .i_ready   (i_ready)
   );

   // Rule: out[r][c] = in[r][(c+r) mod 4], or (c-r) mod 4 for the inverse.
   function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
      logic [7:0]   b[16];
      logic [127:0] o;
      int           src;
      o = '0;
      for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*(4*c+r) -: 8] = b[4*src + r];
         end
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [127:0] st, input logic [3:0] tg, input logic inv,
                       input logic [127:0] exp);
      logic acc;
      acc       = 1'b0;
      i_valid   = 1'b1;
      i_state   = st;
      i_tag     = tg;
      i_inverse = inv;
      for (int k = 0; k < 300 && !acc; k++) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
      end
      if (acc) exp_q.push_back({exp, tg});
      else begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got o_ready=0 for 300 cycles expected acceptance");
      end
      i_valid = 1'b0;
   endtask

   // Monitor: pops on every output transfer and checks hold stability under stall.
   initial begin
      logic         hold_v;
      logic [127:0] hold_s;
      logic [3:0]   hold_t;
      logic [131:0] e;
      hold_v = 1'b0;
      hold_s = '0;
      hold_t = '0;
      forever begin
         @(negedge clk);
         if (rst) hold_v = 1'b0;
         else begin
            if (hold_v) begin
               chk("hold_valid", {127'd0, o_valid}, 128'd1);
               chk("hold_state", o_state, hold_s);
               chk("hold_tag", {124'd0, o_tag}, {124'd0, hold_t});
            end
            hold_v = o_valid && !i_ready;
            hold_s = o_state;
            hold_t = o_tag;
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL out_unexpected: got tag %h state %h expected no word", o_tag, o_state);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_state", o_state, e[131:4]);
                  chk("out_tag", {124'd0, o_tag}, {124'd0, e[3:0]});
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [127:0] w[4];
      logic [127:0] r;
      logic         inv;
      int           vcnt;
      int           lowcnt;

      rst       = 1'b1;
      i_valid   = 1'b0;
      i_ready   = 1'b1;
      i_state   = '0;
      i_tag     = '0;
      i_inverse = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", {127'd0, o_valid}, 128'd0);
      chk("reset_ready", {127'd0, o_ready}, 128'd1);
      chk("reset_state", o_state, 128'd0);
      chk("reset_tag", {124'd0, o_tag}, 128'd0);
      @(posedge clk);
      #1;

      // FIPS-197 App. B round 1 vector
      send(FIPS_IN, 4'h1, 1'b0, FIPS_OUT);
      @(negedge clk);
      chk("fips_latency_valid", {127'd0, o_valid}, 128'd1);
      chk("fips_state", o_state, FIPS_OUT);
      @(posedge clk);
      #1;

      // Streaming: 8 back-to-back words
      vcnt   = 0;
      lowcnt = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               r = {$urandom, $urandom, $urandom, $urandom};
               send(r, 4'(i), 1'b0, ref_sr(r, 1'b0));
            end
         end
         begin
            for (int k = 1; k <= 9; k++) begin
               @(negedge clk);
               if (!o_ready) lowcnt++;
               if (k >= 2 && o_valid) vcnt++;
            end
         end
      join
      chk("stream_valid_cycles", 128'(vcnt), 128'd8);
      chk("stream_ready_low", 128'(lowcnt), 128'd0);
      @(posedge clk);
      #1;

      // Backpressure: 3 stalled cycles with 4 words offered
      for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};
      i_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(w[i], 4'(8 + i), 1'b0, ref_sr(w[i], 1'b0));
         end
         begin
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            chk("bp_ready_low", {127'd0, o_ready}, 128'd0);
            chk("bp_word0_held", o_state, ref_sr(w[0], 1'b0));
            @(posedge clk);
            #1 i_ready = 1'b1;
         end
      join
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      chk("bp_drained", 128'(exp_q.size()), 128'd0);

      // Reset mid-operation while FULL2
      i_ready = 1'b0;
      r = {$urandom, $urandom, $urandom, $urandom};
      send(r, 4'hA, 1'b0, ref_sr(r, 1'b0));
      send(~r, 4'hB, 1'b0, ref_sr(~r, 1'b0));
      chk("full2_ready_low", {127'd0, o_ready}, 128'd0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_valid", {127'd0, o_valid}, 128'd0);
      chk("midreset_ready", {127'd0, o_ready}, 128'd1);
      chk("midreset_state", o_state, 128'd0);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      r = {$urandom, $urandom, $urandom, $urandom};
      send(r, 4'hC, 1'b0, ref_sr(r, 1'b0));
      @(negedge clk);
      chk("postreset_valid", {127'd0, o_valid}, 128'd1);
      @(negedge clk);
      chk("postreset_alone", {127'd0, o_valid}, 128'd0);
      @(posedge clk);
      #1;

`ifdef SHIFTROWS_PIPE_INV_EN
      send(FIPS_OUT, 4'h2, 1'b1, FIPS_IN);
      @(posedge clk);
      #1;
`endif

      // Randomised traffic with random backpressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         r = {$urandom, $urandom, $urandom, $urandom};
`ifdef SHIFTROWS_PIPE_INV_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         send(r, 4'($urandom), inv, ref_sr(r, inv));
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2 i_ready = 1'b1;
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      chk("final_drained", 128'(exp_q.size()), 128'd0);
      @(negedge clk);
      chk("final_idle_valid", {127'd0, o_valid}, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shiftrows_pipe_stage.md
Name: shiftrows_pipe_stage

Overview:
Registered AES ShiftRows stage with valid/ready flow control and a 2-entry skid buffer.
Sits directly upstream of the combinational MixColumns block in the round datapath.
Consumes the SubBytes output, applies ShiftRows, and presents a registered state plus a sideband tag to the MixColumns/AddRoundKey path.
Breaks the combinational path between SubBytes and MixColumns without losing throughput under backpressure.

Parameters:
NB_BYTE, 8, bits per state byte; only 8 is legal.
N_BYTES, 16, bytes per state; only 16 is legal.
NB_TAG, 4, width of the sideband tag (round index / context id) carried alongside the state.

Ports:
i_clock  in  1  clock.
i_reset  in  1  synchronous active-high reset.
i_state  in  N_BYTES*NB_BYTE  input state; columns consecutive, column 0 on MSB.
i_tag  in  NB_TAG  sideband tag, travels with i_state.
i_valid  in  1  upstream word valid.
o_ready  out  1  stage can accept a word this cycle; registered.
o_state  out  N_BYTES*NB_BYTE  ShiftRows result, same byte layout as i_state.
o_tag  out  NB_TAG  tag of o_state.
o_valid  out  1  o_state/o_tag valid.
i_ready  in  1  downstream accepts the word this cycle.

Behaviour:
- Byte layout: byte b = 4*c + r (column c, row r) occupies bits [N_BYTES*NB_BYTE-1-8b -: 8].
- Transform: out[r][c] = in[r][(c+r) mod 4].
  - Row 0 unchanged; row 1 rotated left by 1, row 2 by 2, row 3 by 3.
  - Applied combinationally on the input side, before registering.
- Transfers: an input transfer occurs when i_valid && o_ready; an output transfer when o_valid && i_ready.
- Storage is two entries:
  - main register: drives o_state, o_tag, o_valid.
  - skid register: holds one overflow word.
- o_ready = !skid_valid, registered.
- State machine (implicit in the two valid flags):
  - EMPTY (main 0, skid 0): input transfer loads main. Next state FULL1.
  - FULL1 (main 1, skid 0):
    - input and output transfer together: main reloads with the new word; stay FULL1.
    - output only: go to EMPTY.
    - input only: the word goes to skid; go FULL2.
  - FULL2 (main 1, skid 1): o_ready = 0, so no input is taken.
    - output transfer: skid moves to main, skid clears; go FULL1.
- Latency is 1 cycle from input transfer to o_valid when unstalled. Sustained throughput is 1 word/cycle.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- o_state/o_tag are held stable while o_valid && !i_ready.
- i_valid while o_ready = 0 is ignored. Upstream must hold the word.
- Reset, including mid-operation: in-flight words are discarded.
  - In the cycle after i_reset: o_valid = 0, o_ready = 1, skid_valid = 0.
  - o_state and o_tag reset to all zeros.
- Data registers load only on their enables. Valid flags alone are reset-critical.
- BAD_CONF (NB_BYTE != 8 or N_BYTES != 16) is a compile-time error via generate-time check.

Optional Feature:
SHIFTROWS_PIPE_INV_EN:
- Defined: adds input port i_inverse (1 bit, sampled with i_state at the input transfer). When 1, the stage applies InvShiftRows instead: out[r][c] = in[r][(c-r) mod 4]. This lets decryption rounds share the stage.
- Undefined: the port is absent and only forward ShiftRows is built.

Decomposition:
- Shared package aes_pkg:
  - NB_BYTE, N_BYTES, N_ROWS, N_COLS constants.
  - A byte-index function (row, col) -> bit offset, shared with the MixColumns and SubBytes stages.
- Natural sub-module: shiftrows_comb, purely combinational, with a forward/inverse select when SHIFTROWS_PIPE_INV_EN is defined. The parent keeps only the skid/valid logic.

Test Plan:
1. FIPS-197 App. B round 1, tag 0x1, i_ready = 1:
   - Stimulus: i_state = d42711aee0bf98f1b8b45de51e415230.
   - Response: one cycle later o_valid = 1, o_state = d4bf5d30e0b452aeb84111f11e2798e5, o_tag = 0x1.
2. Streaming: 8 back-to-back words (tags 0..7), i_ready held 1 -> o_valid continuous for 8 cycles, tags 0..7 in order, o_ready never 0.
3. Backpressure: i_ready = 0 for 3 cycles while i_valid is held with 4 words.
   - Words 0 and 1 are accepted, then o_ready = 0 and the stage holds.
   - Word 0 stays stable on o_state.
   - After i_ready = 1, output order is 0, 1, 2, 3 with no loss.
4. Simultaneous input and output transfer in FULL1 -> main reloads, skid stays empty, o_ready stays 1.
5. Reset mid-operation in FULL2 (i_reset pulsed 1 cycle):
   - Next cycle: o_valid = 0, o_ready = 1, o_state = 0.
   - The next input appears alone after 1 cycle.
6. With SHIFTROWS_PIPE_INV_EN, i_inverse = 1:
   - Stimulus: i_state = d4bf5d30e0b452aeb84111f11e2798e5.
   - Response: o_state = d42711aee0bf98f1b8b45de51e415230.
